// File: rtl/score_text_renderer_pkg.sv
// Shared types, geometry constants and font helpers for the score text band renderer.
// The font is a seven-segment style face: each code lights a subset of segments a..g.
package score_text_renderer_pkg;

    typedef enum logic {
        StIdle,
        StFlash
    } flash_state_e;

    localparam int unsigned TEXT_COLS = 40;
    localparam int unsigned CELL_W    = 16;
    localparam int unsigned GLYPH_H   = 16;

    localparam logic [5:0] SCORE_FIRST_SLOT = 6'd21;
    localparam logic [5:0] SCORE_LAST_SLOT  = 6'd27;
    localparam logic [3:0] CODE_BLANK       = 4'hf;

    // Segment bits ordered {a, b, c, d, e, f, g}.
    function automatic logic [6:0] seg_mask(input logic [3:0] code);
        logic [6:0] m;
        case (code)
            4'h0:       m = 7'h7e;
            4'h1:       m = 7'h30;
            4'h2:       m = 7'h6d;
            4'h3:       m = 7'h79;
            4'h4:       m = 7'h33;
            4'h5:       m = 7'h5b;
            4'h6:       m = 7'h5f;
            4'h7:       m = 7'h70;
            4'h8:       m = 7'h7f;
            4'h9:       m = 7'h7b;
            4'ha:       m = 7'h77;
            4'hb:       m = 7'h1f;
            4'hc:       m = 7'h4e;
            4'hd:       m = 7'h3d;
            4'he:       m = 7'h4f;
            CODE_BLANK: m = 7'h00;
            default:    m = 7'h00;
        endcase
        return m;
    endfunction

    function automatic logic in_rows(input logic [3:0] row, input logic [3:0] lo,
                                     input logic [3:0] hi);
        return (row >= lo) && (row <= hi);
    endfunction

endpackage

// File: rtl/score_text_renderer_font_rom.sv
// Synchronous 256x8 glyph ROM, address {code, row}, one cycle read latency.
// Bit 7 of each byte is the leftmost glyph column.
module score_font_rom
    import score_text_renderer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_addr,
    output logic [7:0] o_data
);

    logic [3:0] w_code;
    logic [3:0] w_row;
    logic [6:0] w_seg;
    logic [7:0] w_byte;
    logic [7:0] r_data;

    assign w_code = i_addr[7:4];
    assign w_row  = i_addr[3:0];
    assign w_seg  = seg_mask(w_code);

    // Horizontal bars span columns 1..6, vertical bars are two columns wide.
    always_comb begin
        w_byte = 8'h00;
        if (w_seg[6] && in_rows(w_row, 4'd1, 4'd2))   w_byte = w_byte | 8'b0111_1110;
        if (w_seg[5] && in_rows(w_row, 4'd1, 4'd8))   w_byte = w_byte | 8'b0000_0110;
        if (w_seg[4] && in_rows(w_row, 4'd7, 4'd14))  w_byte = w_byte | 8'b0000_0110;
        if (w_seg[3] && in_rows(w_row, 4'd13, 4'd14)) w_byte = w_byte | 8'b0111_1110;
        if (w_seg[2] && in_rows(w_row, 4'd7, 4'd14))  w_byte = w_byte | 8'b0110_0000;
        if (w_seg[1] && in_rows(w_row, 4'd1, 4'd8))   w_byte = w_byte | 8'b0110_0000;
        if (w_seg[0] && in_rows(w_row, 4'd7, 4'd8))   w_byte = w_byte | 8'b0111_1110;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= 8'h00;
        end else begin
            r_data <= w_byte;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/score_text_renderer.sv
// Three-stage pixel pipeline drawing a 40-cell, 16-line text band, with the score
// digits (slots 21..27) flashing for a number of frames after each score change.
module score_text_renderer
    import score_text_renderer_pkg::*;
#(
    parameter logic [9:0] TEXT_Y0      = 10'd464,
    parameter logic [5:0] FLASH_FRAMES = 6'd32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pixel_valid,
    input  logic       score_changed,
    output logic [5:0] CHAR_ADDR,
    input  logic [3:0] CHAR_DATA,
    output logic       text_on,
    output logic       text_valid
);

    localparam logic [10:0] BAND_END  = 11'(TEXT_Y0) + 11'(GLYPH_H);
    localparam logic [9:0]  VISIBLE_W = 10'(TEXT_COLS * CELL_W);

    logic       w_in_band;
    logic [3:0] w_row;
    logic [2:0] w_bit;
    logic       w_tick;
    logic [7:0] w_glyph;
    logic       w_blank;

    logic [5:0] r_char_addr;
    logic [3:0] r_row1;
    logic [2:0] r_bit1;
    logic       r_in_band1;
    logic       r_valid1;

    logic [2:0] r_bit2;
    logic       r_in_band2;
    logic       r_valid2;
    logic [5:0] r_slot2;

    logic       r_text_on;
    logic       r_text_valid;

    flash_state_e r_state, w_state_d;
    logic [5:0]   r_flash_cnt, w_cnt_d;

    assign w_in_band = pixel_valid && (DrawY >= TEXT_Y0) && ({1'b0, DrawY} < BAND_END)
                       && (DrawX < VISIBLE_W);
    // Only the low nibble of the band offset is needed, so subtract nibbles directly.
    assign w_row  = DrawY[3:0] - TEXT_Y0[3:0];
    assign w_bit  = 3'd7 - DrawX[3:1];
    assign w_tick = pixel_valid && (DrawX == 10'd0) && (DrawY == 10'd0);

    // Stage 1: slot address to the character source.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_char_addr <= 6'd0;
            r_row1      <= 4'd0;
            r_bit1      <= 3'd0;
            r_in_band1  <= 1'b0;
            r_valid1    <= 1'b0;
        end else begin
            r_char_addr <= w_in_band ? (DrawX[9:4] + 6'd1) : 6'd0;
            r_row1      <= w_row;
            r_bit1      <= w_bit;
            r_in_band1  <= w_in_band;
            r_valid1    <= pixel_valid;
        end
    end

    assign CHAR_ADDR = r_char_addr;

    // Stage 2: glyph byte fetch; side-band delayed to line up with the ROM output.
    score_font_rom u_font_rom (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_addr ({CHAR_DATA, r_row1}),
        .o_data (w_glyph)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bit2     <= 3'd0;
            r_in_band2 <= 1'b0;
            r_valid2   <= 1'b0;
            r_slot2    <= 6'd0;
        end else begin
            r_bit2     <= r_bit1;
            r_in_band2 <= r_in_band1;
            r_valid2   <= r_valid1;
            r_slot2    <= r_char_addr;
        end
    end

    // Stage 3: pixel select and flash masking.
    assign w_blank = (r_state == StFlash) && r_flash_cnt[2]
                     && (r_slot2 >= SCORE_FIRST_SLOT) && (r_slot2 <= SCORE_LAST_SLOT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_text_on    <= 1'b0;
            r_text_valid <= 1'b0;
        end else begin
            r_text_on    <= r_valid2 && r_in_band2 && w_glyph[r_bit2] && !w_blank;
            r_text_valid <= r_valid2;
        end
    end

    assign text_on    = r_text_on;
    assign text_valid = r_text_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_flash_cnt <= 6'd0;
        end else begin
            r_state     <= w_state_d;
            r_flash_cnt <= w_cnt_d;
        end
    end

    // A score change always reloads, even when it lands on a frame tick.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_flash_cnt;
        case (r_state)
            StIdle: begin
                if (score_changed) begin
                    w_state_d = StFlash;
                    w_cnt_d   = FLASH_FRAMES;
                end
            end
            StFlash: begin
                if (score_changed) begin
                    w_cnt_d = FLASH_FRAMES;
                end else if (w_tick) begin
                    w_cnt_d = (r_flash_cnt == 6'd0) ? 6'd0 : (r_flash_cnt - 6'd1);
                    if (r_flash_cnt <= 6'd1) begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_score_text_renderer.sv
// Randomized bench for score_text_renderer with a pixel-geometry font model and a
// frame-count flash model.
module tb_score_text_renderer;

    localparam int TY0     = 464;
    localparam int FLASH_N = 32;

    logic       Clk           = 1'b0;
    logic       Reset         = 1'b1;
    logic [9:0] DrawX         = '0;
    logic [9:0] DrawY         = '0;
    logic       pixel_valid   = 1'b0;
    logic       score_changed = 1'b0;
    logic [5:0] CHAR_ADDR;
    logic [3:0] CHAR_DATA;
    logic       text_on;
    logic       text_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] src [64];
    string      seg_names [16];

    bit m_flash = 0;
    int m_cnt   = 0;
    bit e_v  [3];
    bit e_on [3];
    int e_addr = 0;

    int probes [12] = '{8, 9, 10, 11, 12, 21, 22, 23, 24, 25, 26, 27};

    always #5 Clk = ~Clk;

    always_comb CHAR_DATA = src[CHAR_ADDR];

    score_text_renderer dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .pixel_valid   (pixel_valid),
        .score_changed (score_changed),
        .CHAR_ADDR     (CHAR_ADDR),
        .CHAR_DATA     (CHAR_DATA),
        .text_on       (text_on),
        .text_valid    (text_valid)
    );

    // Segment rectangles in glyph coordinates (gx 0..7 left to right, gy 0..15).
    function automatic bit seg_lit(byte s, int gx, int gy);
        case (s)
            "a": return gy >= 1 && gy <= 2 && gx >= 1 && gx <= 6;
            "b": return gy >= 1 && gy <= 8 && gx >= 5 && gx <= 6;
            "c": return gy >= 7 && gy <= 14 && gx >= 5 && gx <= 6;
            "d": return gy >= 13 && gy <= 14 && gx >= 1 && gx <= 6;
            "e": return gy >= 7 && gy <= 14 && gx >= 1 && gx <= 2;
            "f": return gy >= 1 && gy <= 8 && gx >= 1 && gx <= 2;
            "g": return gy >= 7 && gy <= 8 && gx >= 1 && gx <= 6;
            default: return 0;
        endcase
    endfunction

    function automatic bit font_lit(int code, int gx, int gy);
        string s;
        s = seg_names[code];
        for (int i = 0; i < s.len(); i++) begin
            if (seg_lit(s[i], gx, gy)) return 1;
        end
        return 0;
    endfunction

    function automatic void model_pixel(input int x, input int y, input bit v,
                                        output bit on, output int addr);
        bit inb;
        int slot;
        bit masked;
        inb  = v && y >= TY0 && y < TY0 + 16 && x < 640;
        slot = x / 16 + 1;
        on   = 0;
        addr = 0;
        if (inb) begin
            addr   = slot;
            masked = m_flash && (m_cnt % 8) >= 4 && slot >= 21 && slot <= 27;
            on     = font_lit(int'(src[slot]), (x % 16) / 2, y - TY0) && !masked;
        end
    endfunction

    function automatic void model_flash(bit sc, bit tick);
        if (sc) begin
            m_flash = 1;
            m_cnt   = FLASH_N;
        end else if (m_flash && tick) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_flash = 0;
        end
    endfunction

    // Drives one cycle, advances the reference pipeline, samples 1 time unit after the edge.
    task automatic step(input int x, input int y, input bit v, input bit sc);
        bit on;
        int addr;
        DrawX         = 10'(x);
        DrawY         = 10'(y);
        pixel_valid   = v;
        score_changed = sc;
        model_pixel(x, y, v, on, addr);
        @(posedge Clk);
        if (Reset) begin
            e_v     = '{default: 1'b0};
            e_on    = '{default: 1'b0};
            e_addr  = 0;
            m_flash = 0;
            m_cnt   = 0;
        end else begin
            model_flash(sc, v && x == 0 && y == 0);
            e_v[2]  = e_v[1];
            e_v[1]  = e_v[0];
            e_v[0]  = v;
            e_on[2] = e_on[1];
            e_on[1] = e_on[0];
            e_on[0] = on;
            e_addr  = addr;
        end
        #1;
    endtask

    task automatic idle();
        step(700, 500, 0, 0);
    endtask

    task automatic frame_tick();
        step(0, 0, 1, 0);
        repeat (3) idle();
    endtask

    task automatic pulse_score();
        step(700, 500, 0, 1);
        repeat (3) idle();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(336, TY0, 1, 0);
        step(338, TY0 + 1, 1, 0);
        idle();
        n_checks++;
        if (CHAR_ADDR !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_addr got %0d want 0", CHAR_ADDR);
        end
        n_checks++;
        if (text_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_text_on got %b want 0", text_on);
        end
        n_checks++;
        if (text_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_text_valid got %b want 0", text_valid);
        end
        Reset = 1'b0;
    endtask

    task automatic test_out_of_band();
        for (int x = 0; x < 643; x++) begin
            if (x < 640) step(x, TY0 - 1, 1'($urandom_range(0, 1)), 0);
            else idle();
            n_checks++;
            if (CHAR_ADDR !== 6'd0) begin
                n_fail++;
                $display("FAIL oob_addr x=%0d got %0d want 0", x, CHAR_ADDR);
            end
            n_checks++;
            if (text_on !== 1'b0) begin
                n_fail++;
                $display("FAIL oob_text_on x=%0d got %b want 0", x, text_on);
            end
            n_checks++;
            if (text_valid !== e_v[2]) begin
                n_fail++;
                $display("FAIL oob_text_valid x=%0d got %b want %b", x, text_valid, e_v[2]);
            end
        end
    endtask

    task automatic test_inband_latency();
        src[22] = 4'h0;
        step(336, TY0, 1, 0);
        n_checks++;
        if (CHAR_ADDR !== 6'd22) begin
            n_fail++;
            $display("FAIL lat_addr got %0d want 22", CHAR_ADDR);
        end
        idle();
        n_checks++;
        if (text_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_early_valid got %b want 0", text_valid);
        end
        idle();
        n_checks++;
        if (text_valid !== 1'b1 || text_on !== 1'(font_lit(0, 0, 0))) begin
            n_fail++;
            $display("FAIL lat_pix0 got valid=%b on=%b want valid=1 on=%b",
                     text_valid, text_on, font_lit(0, 0, 0));
        end
        // Row 1, column 1 of digit 0 is on the top bar.
        step(338, TY0 + 1, 1, 0);
        n_checks++;
        if (text_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_gap_valid got %b want 0", text_valid);
        end
        idle();
        idle();
        n_checks++;
        if (text_valid !== 1'b1 || text_on !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_pix1 got valid=%b on=%b want valid=1 on=1", text_valid, text_on);
        end
        idle();
    endtask

    task automatic test_blank();
        src[40] = 4'hf;
        for (int i = 0; i < 259; i++) begin
            if (i < 256) step(624 + (i % 16), TY0 + i / 16, 1, 0);
            else idle();
            n_checks++;
            if (CHAR_ADDR !== 6'(e_addr)) begin
                n_fail++;
                $display("FAIL blank_addr i=%0d got %0d want %0d", i, CHAR_ADDR, e_addr);
            end
            n_checks++;
            if (text_on !== 1'b0) begin
                n_fail++;
                $display("FAIL blank_text_on i=%0d got %b want 0", i, text_on);
            end
            n_checks++;
            if (text_valid !== e_v[2]) begin
                n_fail++;
                $display("FAIL blank_text_valid i=%0d got %b want %b", i, text_valid, e_v[2]);
            end
        end
    endtask

    task automatic test_random_pixels();
        for (int s = 1; s <= 40; s++) src[s] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 603; i++) begin
            if (i < 600) step($urandom_range(0, 799), TY0 - 2 + $urandom_range(0, 19),
                              $urandom_range(0, 3) != 0, 0);
            else idle();
            n_checks++;
            if (CHAR_ADDR !== 6'(e_addr)) begin
                n_fail++;
                $display("FAIL rand_addr i=%0d got %0d want %0d", i, CHAR_ADDR, e_addr);
            end
            n_checks++;
            if (text_on !== e_on[2]) begin
                n_fail++;
                $display("FAIL rand_text_on i=%0d got %b want %b", i, text_on, e_on[2]);
            end
            n_checks++;
            if (text_valid !== e_v[2]) begin
                n_fail++;
                $display("FAIL rand_text_valid i=%0d got %b want %b", i, text_valid, e_v[2]);
            end
        end
    endtask

    task automatic test_flash();
        for (int p = 0; p < 12; p++) src[probes[p]] = 4'h8;
        pulse_score();
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) frame_tick();
            for (int i = 0; i < 15; i++) begin
                if (i < 12) step((probes[i] - 1) * 16 + 2 * $urandom_range(1, 6)
                                 + $urandom_range(0, 1), TY0 + 1, 1, 0);
                else idle();
                n_checks++;
                if (text_on !== e_on[2] || text_valid !== e_v[2]) begin
                    n_fail++;
                    $display("FAIL flash_pix tick=%0d i=%0d got on=%b valid=%b want on=%b valid=%b",
                             t, i, text_on, text_valid, e_on[2], e_v[2]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        src[22] = 4'h8;
        pulse_score();
        repeat (FLASH_N - 5) frame_tick();
        // Reload and frame tick together: reload must win, leaving the count at 32.
        step(0, 0, 1, 1);
        repeat (3) idle();
        step(21 * 16 + 2, TY0 + 1, 1, 0);
        idle();
        idle();
        n_checks++;
        if (text_on !== 1'b1 || text_on !== e_on[2]) begin
            n_fail++;
            $display("FAIL simul_reload got %b want 1 (model %b)", text_on, e_on[2]);
        end
        idle();
        frame_tick();
        step(21 * 16 + 4, TY0 + 2, 1, 0);
        idle();
        idle();
        n_checks++;
        if (text_on !== 1'b0 || text_on !== e_on[2]) begin
            n_fail++;
            $display("FAIL simul_after_tick got %b want 0 (model %b)", text_on, e_on[2]);
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        for (int s = 19; s <= 29; s++) src[s] = 4'h8;
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(19 * 16, 28 * 16 - 1), TY0 + $urandom_range(0, 15), 1, 0);
            if (i == 11) Reset = 1'b0;
            n_checks++;
            if (CHAR_ADDR !== 6'(e_addr) || text_on !== e_on[2] || text_valid !== e_v[2]) begin
                n_fail++;
                $display("FAIL rst_stream i=%0d got addr=%0d on=%b valid=%b want %0d %b %b",
                         i, CHAR_ADDR, text_on, text_valid, e_addr, e_on[2], e_v[2]);
            end
            if (i == 10) begin
                #2;
                Reset = 1'b1;
                #1;
                n_checks++;
                if (CHAR_ADDR !== 6'd0 || text_on !== 1'b0 || text_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_async got addr=%0d on=%b valid=%b want 0 0 0",
                             CHAR_ADDR, text_on, text_valid);
                end
            end
            if (i == 13) begin
                n_checks++;
                if (text_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_resume_early got %b want 0", text_valid);
                end
            end
            if (i == 14) begin
                n_checks++;
                if (text_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_resume got %b want 1", text_valid);
                end
            end
        end
        repeat (3) idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_names[0]  = "abcdef";
        seg_names[1]  = "bc";
        seg_names[2]  = "abdeg";
        seg_names[3]  = "abcdg";
        seg_names[4]  = "bcfg";
        seg_names[5]  = "acdfg";
        seg_names[6]  = "acdefg";
        seg_names[7]  = "abc";
        seg_names[8]  = "abcdefg";
        seg_names[9]  = "abcdfg";
        seg_names[10] = "abcefg";
        seg_names[11] = "cdefg";
        seg_names[12] = "adef";
        seg_names[13] = "bcdeg";
        seg_names[14] = "adefg";
        seg_names[15] = "";
        for (int s = 0; s < 64; s++) src[s] = 4'($urandom_range(0, 15));
        e_v  = '{default: 1'b0};
        e_on = '{default: 1'b0};

        test_reset();
        test_out_of_band();
        test_inband_latency();
        test_blank();
        test_random_pixels();
        test_flash();
        test_simultaneous();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_text_renderer.md
SCORE_TEXT_RENDERER -- requirements
Module: score_text_renderer

Interface
REQ-001 Parameter TEXT_Y0, default 10'd464, first screen line of the 16-line score text band.
REQ-002 Parameter FLASH_FRAMES, default 6'd32, number of frames the score digits flash after a score change.
REQ-003 Clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 DrawX  input  10  current pixel column, 0..799; visible columns 0..639.
REQ-006 DrawY  input  10  current pixel row, 0..524; visible rows 0..479.
REQ-007 pixel_valid  input  1  DrawX/DrawY are valid this cycle.
REQ-008 score_changed  input  1  single-cycle pulse when the displayed score value changes.
REQ-009 CHAR_ADDR  output  6  character slot address, 1..40, sent to the score character source.
REQ-010 CHAR_DATA  input  4  character code returned combinationally for CHAR_ADDR; 0-9 are digits, a-e are letters, f is blank.
REQ-011 text_on  output  1  the pixel is lit foreground text.
REQ-012 text_valid  output  1  text_on corresponds to a pixel_valid input presented 3 cycles earlier.

Function
REQ-013 Band membership: in_band = pixel_valid & (DrawY >= TEXT_Y0) & (DrawY < TEXT_Y0+16) & (DrawX < 640).
REQ-014 Cell geometry: 40 cells of 16 px each; col = DrawX[9:4]; glyph row = (DrawY - TEXT_Y0)[3:0]; glyph bit = 7 - DrawX[3:1], so each 8-px glyph is drawn 2x horizontally.
REQ-015 Stage 1 (registered): CHAR_ADDR = col+1 when in_band, else 6'd0; row, bit, in_band and pixel_valid are registered alongside it.
REQ-016 Stage 2 (registered): font ROM read at address {CHAR_DATA, row}, producing an 8-bit glyph byte; row/bit/in_band/valid/slot are delayed to match.
REQ-017 Stage 3 (registered): text_on = valid & in_band & glyph[bit] & ~blank_mask; text_valid = delayed pixel_valid.
REQ-018 Latency: exactly 3 Clk cycles from the pixel_valid input to text_valid/text_on; throughput is 1 pixel per cycle, with no stalls.
REQ-019 CHAR_DATA = 4'hf gives an all-zero glyph, so text_on = 0.
REQ-020 Frame tick: asserted on a cycle where pixel_valid=1, DrawX=0 and DrawY=0.
REQ-021 Flash FSM states:
- IDLE: on score_changed, go to FLASH and set flash_cnt = FLASH_FRAMES.
- FLASH: on each frame tick, flash_cnt decrements; at flash_cnt = 0, go to IDLE.
REQ-022 score_changed while in FLASH reloads flash_cnt to FLASH_FRAMES and stays in FLASH.
REQ-023 If score_changed and a frame tick occur in the same cycle, the reload wins.
REQ-024 blank_mask = (state == FLASH) & flash_cnt[2] & (slot address in 21..27); digits are therefore hidden for 4 frames out of every 8.
REQ-025 In IDLE, blank_mask = 0.
REQ-026 Slots outside 21..27 are never masked.
REQ-027 flash_cnt is 6 bits and does not underflow; it saturates at 0.

Reset
REQ-028 Reset SHALL asynchronously clear the following to 0: CHAR_ADDR, text_on, text_valid, all pipeline valid/in_band flags, and flash_cnt; state SHALL go to IDLE.
REQ-029 Reset asserted mid-frame or mid-flash SHALL discard in-flight pixels; text_valid stays 0 until 3 cycles after the first post-reset pixel_valid.

Structure
REQ-030 A shared package SHALL hold: the flash state enum, TEXT_COLS = 40, CELL_W = 16, GLYPH_H = 16, SCORE_FIRST_SLOT = 21, SCORE_LAST_SLOT = 27, and CODE_BLANK = 4'hf.
REQ-031 The design SHALL include one sub-module, score_font_rom: a synchronous 256x8 ROM (16 codes x 16 rows), 1-cycle read latency.

Verification
REQ-032 Out-of-band scan: DrawY = TEXT_Y0-1, DrawX sweeps 0..639 -> CHAR_ADDR = 0 and text_on = 0 throughout; text_valid follows pixel_valid delayed by 3 cycles.
REQ-033 In-band address and latency: DrawY = TEXT_Y0, DrawX = 336 -> CHAR_ADDR = 22 one cycle later; text_on matches the glyph for code 0, row 0, bit 7, exactly 3 cycles after input.
REQ-034 Blank code: with the source returning CHAR_DATA = 4'hf for slot 40, scan DrawX 624..639 over all 16 band rows -> text_on = 0 on every pixel.
REQ-035 Flash timing: pulse score_changed, then run 40 frame ticks -> slots 21..27 are masked exactly while flash_cnt[2] = 1 and unmasked after 32 ticks; slots 8..12 are never masked.
REQ-036 Simultaneous events: score_changed on the same cycle as a frame tick with flash_cnt = 5 -> flash_cnt = 32 on the next cycle.
REQ-037 Reset mid-stream: assert Reset for 1 cycle during continuous in-band pixels with flash active -> all outputs are 0 immediately, state = IDLE, and text_valid resumes exactly 3 cycles after Reset deasserts.
